// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receive FSM states, data width, baud divider math.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DATA_BITS = 8;

  // sysclk cycles per oversample tick, rounded to nearest
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Byte handshake between the UART receive front end and its consumer.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample divider; one-cycle tick every DIV sysclk, clear realigns phase.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 receiver: 16x oversampled start/data/stop sampling, byte held until rx_valid & rx_ready.
// A byte finishing while one is still pending is dropped and flagged via sticky overrun.
module uart_rx_frame import uart_pkg::*; #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               UART_RX,
  input  logic               recv_enable,
  output logic               busy,
  uart_rx_frame_if.master    rx
);

  localparam int              DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int              SW    = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]   MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]   SLAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state, nstate;
  logic                 rx_s1, rx_s2, rx_d;
  logic                 fall;
  logic                 tick;
  logic                 sample;
  logic                 start_hit;
  logic                 shift_en;
  logic                 frame_good;
  logic                 frame_bad;
  logic [SW-1:0]        scnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 handshake;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= UART_RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall   = rx_d & ~rx_s2;
  assign sample = tick && (scnt == MID);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (sysclk),
    .rst  (reset),
    .clr  (start_hit),
    .tick (tick)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate     = state;
    start_hit  = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (recv_enable && fall) begin
          nstate    = START;
          start_hit = 1'b1;
        end
      end
      START: begin
        if (!recv_enable)
          nstate = IDLE;
        else if (sample)
          nstate = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (!recv_enable)
          nstate = IDLE;
        else if (sample) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT)
            nstate = STOP;
        end
      end
      STOP: begin
        if (!recv_enable)
          nstate = IDLE;
        else if (sample) begin
          // Back to IDLE on the midpoint so a start edge right after is not missed
          nstate     = IDLE;
          frame_good = rx_s2;
          frame_bad  = ~rx_s2;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE)
        scnt <= '0;
      else if (tick)
        scnt <= (scnt == SLAST) ? '0 : scnt + 1'b1;

      if (state != DATA)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;

      if (shift_en)
        shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
    end
  end

  assign handshake = rx.rx_valid & rx.rx_ready;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.overrun   <= 1'b0;
      rx.frame_err <= 1'b0;
    end else begin
      rx.frame_err <= frame_bad;
      if (frame_good) begin
        if (!rx.rx_valid || handshake) begin
          rx.rx_data  <= shreg;
          rx.rx_valid <= 1'b1;
          if (handshake)
            rx.overrun <= 1'b0;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (handshake) begin
        rx.rx_valid <= 1'b0;
        rx.overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 160 sysclk per bit; queue scoreboard checks bytes and frame errors.
module tb_uart_rx_frame;

  localparam int BIT = 160;

  logic sysclk;
  logic reset;
  logic uart_rx;
  logic recv_enable;
  logic busy;

  uart_rx_frame_if rif();

  uart_rx_frame #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .UART_RX     (uart_rx),
    .recv_enable (recv_enable),
    .busy        (busy),
    .rx          (rif.master)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d);
    sbq.push_back('{1'b0, d});
  endtask

  task automatic expect_err();
    sbq.push_back('{1'b1, 8'h00});
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge
  task automatic wait_clk(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic line_bit(input logic b, input int n);
    uart_rx = b;
    wait_clk(n);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    line_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) line_bit(d[i], BIT);
    line_bit(stop, BIT);
    line_bit(1'b1, 40);
  endtask

  // Start bit plus n data bits, then stops halfway through data bit n
  task automatic send_head(input logic [7:0] d, input int n);
    line_bit(1'b0, BIT);
    for (int i = 0; i < n; i++) line_bit(d[i], BIT);
    line_bit(d[n], BIT / 2);
  endtask

  always @(negedge sysclk) begin
    if (!reset) begin
      if (rif.frame_err) begin
        vectors++;
        if (sbq.size() == 0 || !sbq[0].is_err) begin
          miscompares++;
          $display("FAIL frame_err: got unexpected pulse, expected none");
        end else begin
          mon_e = sbq.pop_front();
        end
      end
      if (rif.rx_valid && rif.rx_ready) begin
        vectors++;
        if (sbq.size() == 0 || sbq[0].is_err) begin
          miscompares++;
          $display("FAIL rx_byte: got unexpected byte %02h, expected none", rif.rx_data);
        end else begin
          mon_e = sbq.pop_front();
          if (rif.rx_data !== mon_e.data) begin
            miscompares++;
            $display("FAIL rx_data: got %02h, expected %02h", rif.rx_data, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    uart_rx      = 1'b1;
    recv_enable  = 1'b1;
    rif.rx_ready = 1'b1;
    wait_clk(3);
    check("rst_rx_valid",  rif.rx_valid,  0);
    check("rst_rx_data",   rif.rx_data,   0);
    check("rst_frame_err", rif.frame_err, 0);
    check("rst_overrun",   rif.overrun,   0);
    check("rst_busy",      busy,          0);
    reset = 1'b0;
    wait_clk(20);

    // 1: good byte, consumer always ready
    expect_byte(8'hA5);
    send_byte(8'hA5, 1'b1);
    check("t1_rx_valid", rif.rx_valid, 0);
    check("t1_overrun",  rif.overrun,  0);
    check("t1_busy",     busy,         0);
    check("t1_drain",    sbq.size(),   0);

    // 2: 30-cycle glitch aborts in START
    line_bit(1'b0, 10);
    check("t2_busy_in", busy, 1);
    line_bit(1'b0, 20);
    line_bit(1'b1, 100);
    check("t2_busy_out", busy, 0);
    check("t2_rx_valid", rif.rx_valid, 0);

    // 3: bad stop bit
    expect_err();
    send_byte(8'h3C, 1'b0);
    check("t3_rx_valid", rif.rx_valid, 0);
    check("t3_busy",     busy,         0);
    check("t3_drain",    sbq.size(),   0);

    // 4: second byte overruns a pending one
    rif.rx_ready = 1'b0;
    expect_byte(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("t4_rx_valid", rif.rx_valid, 1);
    check("t4_rx_data",  rif.rx_data,  8'h11);
    check("t4_overrun",  rif.overrun,  1);
    rif.rx_ready = 1'b1;
    wait_clk(1);
    check("t4_valid_clr",   rif.rx_valid, 0);
    check("t4_overrun_clr", rif.overrun,  0);
    check("t4_drain",       sbq.size(),   0);

    // 5: async reset mid-frame with a pending byte and overrun set
    rif.rx_ready = 1'b0;
    send_byte(8'h77, 1'b1);
    send_byte(8'h66, 1'b1);
    check("t5_pre_overrun", rif.overrun, 1);
    send_head(8'h99, 4);
    check("t5_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_rx_valid",  rif.rx_valid,  0);
    check("t5_rx_data",   rif.rx_data,   0);
    check("t5_overrun",   rif.overrun,   0);
    check("t5_frame_err", rif.frame_err, 0);
    check("t5_busy",      busy,          0);
    uart_rx = 1'b1;
    wait_clk(5);
    reset        = 1'b0;
    rif.rx_ready = 1'b1;
    wait_clk(20);
    expect_byte(8'h5A);
    send_byte(8'h5A, 1'b1);
    check("t5_drain", sbq.size(), 0);

    // 6: receiver disabled mid-frame
    send_head(8'hFF, 2);
    recv_enable = 1'b0;
    wait_clk(2);
    check("t6_busy", busy, 0);
    wait_clk(BIT * 6);
    check("t6_rx_valid", rif.rx_valid, 0);
    recv_enable = 1'b1;
    wait_clk(10);
    expect_byte(8'h81);
    send_byte(8'h81, 1'b1);
    check("t6_drain", sbq.size(), 0);
    check("end_rx_valid", rif.rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
